lstm_cell: RTL and testbench
============================

Name: lstm_cell

Overview:
- Single-unit scalar LSTM cell, signed fixed-point.
- Accepts one input sample with the previous cell/hidden state and per-gate weights/biases.
- Produces the new cell state C_out and hidden output y_out after a fixed latency.
- Intended as the datapath core of a sequence-processing engine; the caller feeds y_out/C_out back as h_in/C_in.

Parameters:
- WEIGHTS, 4, number of gates; fixed at 4 (index 0=i input, 1=f forget, 2=g candidate, 3=o output).
- WIDTH, 16, bit width of every data word, signed two's complement.
- FRAC, 12, fractional bits (Q3.12 at defaults); ONE = 1<<FRAC = 4096.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- weight_x  in  WEIGHTS*WIDTH  signed packed array, per-gate input weights.
- weight_h  in  WEIGHTS*WIDTH  signed packed array, per-gate recurrent weights.
- bias_x  in  WEIGHTS*WIDTH  signed packed array, per-gate input biases.
- bias_h  in  WEIGHTS*WIDTH  signed packed array, per-gate recurrent biases.
- C_in  in  WIDTH  previous cell state.
- h_in  in  WIDTH  previous hidden state.
- x_in  in  WIDTH  input sample.
- x_valid  in  1  input valid.
- x_ready  out  1  cell can accept input.
- C_out  out  WIDTH  new cell state.
- y_out  out  WIDTH  new hidden state/output.
- y_valid  out  1  one-cycle pulse; C_out/y_out are valid.

Behaviour:
- Reset (rst=0 at clk edge):
  - state IDLE; x_ready=1 after release.
  - C_out=0, y_out=0, y_valid=0.
  - Reset mid-operation aborts the computation; no y_valid follows.
- Handshake: transfer when x_valid && x_ready.
  - All inputs, including weights and biases, are captured on the transfer edge; later input changes are ignored.
  - x_ready=1 only in IDLE.
- FSM: IDLE -> S_PRE -> S_ACT -> S_CELL -> S_OUT -> IDLE, one cycle each. The registers written in each state:
  - S_PRE: pre[k] = sat(mul(weight_x[k],x) + bias_x[k] + mul(weight_h[k],h) + bias_h[k]), sum held in WIDTH+3 bits.
  - S_ACT: i=hsig(pre0), f=hsig(pre1), g=htanh(pre2), o=hsig(pre3).
  - S_CELL: C_out = sat(mul(f,C_in) + mul(i,g)).
  - S_OUT: y_out = sat(mul(o, htanh(C_out))); y_valid=1 this cycle; return to IDLE.
- Latency and throughput:
  - y_valid asserts exactly 4 cycles after the transfer edge.
  - Throughput is one sample per 5 cycles with x_valid held high.
- C_out/y_out hold their value until the next result; y_valid is low otherwise.
- Arithmetic rules:
  - mul(a,b) = (a*b) full 2*WIDTH product, arithmetic shift right FRAC (truncation toward -inf).
  - sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - hsig(x) = clamp((x>>>2) + ONE/2, 0, ONE).
  - htanh(x) = clamp(x, -ONE, ONE).
- Saturation is never an error; there are no status flags.

Optional Feature:
- Macro LSTM_ROUND_EN.
- Defined: every mul() adds 1<<(FRAC-1) before the shift (round half up).
- Undefined: pure truncation as above.
- Latency and interface are identical either way.

Decomposition:
- Package lstm_pkg holds:
  - gate index constants GATE_I/F/G/O;
  - FRAC default and ONE;
  - functions sat, mul, hsig, htanh, parameterised by WIDTH via localparams.
- One sub-module, lstm_gate, computes one gate's saturated preactivation. It is instantiated WEIGHTS times in a generate loop.

Test Plan:
- Reset behaviour: hold rst=0 for 10 cycles, then release.
  - Required: C_out=0, y_out=0, y_valid=0, x_ready=1.
- Zero parameters: all weights/biases 0, C_in=4096, h_in=123, x_in=-77.
  - Gate values: i=f=o=2048, g=0.
  - Required: C_out=2048, y_out=1024, y_valid exactly 4 cycles after accept.
- Saturation: bias_x[1]=bias_h[1]=32767, all other parameters 0, C_in=-8192.
  - pre1 saturates to 32767, so f=4096.
  - Required: C_out=-8192, y_out=-2048.
- Candidate path: weight_x[2]=4096, x_in=2048, all other parameters 0, C_in=0.
  - g=2048, i=2048.
  - Required: C_out=1024, y_out=512.
- Handshake:
  - x_valid held high with new random data each cycle: x_ready low 4 cycles, accepts every 5th cycle; results match the data captured at accept.
  - rst=0 during S_ACT: no y_valid, C_out=y_out=0.
- Rounding: weight_x[2]=2048, x_in=1, others 0, C_in=0.
  - Without LSTM_ROUND_EN: g=0, C_out=0.
  - With LSTM_ROUND_EN: g=1, C_out=1.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared constants, types and fixed-point helpers for the scalar LSTM cell.
// Optional macro LSTM_ROUND_EN: mul() rounds half up instead of truncating.
package lstm_pkg;

  localparam int unsigned LSTM_WIDTH  = 16;
  localparam int unsigned LSTM_FRAC   = 12;
  localparam int          LSTM_ONE    = 1 << LSTM_FRAC;
  localparam int unsigned LSTM_PRE_W  = LSTM_WIDTH + 3;
  localparam int unsigned LSTM_PROD_W = 2 * LSTM_WIDTH;
  localparam int unsigned LSTM_WIDE_W = LSTM_PROD_W + 1;

  localparam int unsigned GATE_I = 0;
  localparam int unsigned GATE_F = 1;
  localparam int unsigned GATE_G = 2;
  localparam int unsigned GATE_O = 3;

  typedef logic signed [LSTM_WIDTH-1:0]  word_t;
  typedef logic signed [LSTM_PRE_W-1:0]  pre_t;
  typedef logic signed [LSTM_PROD_W-1:0] prod_t;
  typedef logic signed [LSTM_WIDE_W-1:0] wide_t;

  typedef enum logic [2:0] {StIdle, StPre, StAct, StCell, StOut} state_e;

  localparam wide_t WORD_MAX  = wide_t'((1 << (LSTM_WIDTH - 1)) - 1);
  localparam wide_t WORD_MIN  = -WORD_MAX - wide_t'(1);
  localparam word_t ONE_W     = word_t'(LSTM_ONE);
  localparam word_t NEG_ONE_W = -ONE_W;

  // Clamp a wide intermediate to the signed word range.
  function automatic word_t sat(wide_t v);
    word_t r;
    if (v > WORD_MAX) begin
      r = WORD_MAX[LSTM_WIDTH-1:0];
    end else if (v < WORD_MIN) begin
      r = WORD_MIN[LSTM_WIDTH-1:0];
    end else begin
      r = v[LSTM_WIDTH-1:0];
    end
    return r;
  endfunction

  // Fixed-point multiply; arithmetic shift floors toward -inf.
  function automatic prod_t mul(word_t a, word_t b);
    prod_t p;
    p = prod_t'(a) * prod_t'(b);
`ifdef LSTM_ROUND_EN
    p = p + prod_t'(LSTM_ONE / 2);
`endif
    return p >>> LSTM_FRAC;
  endfunction

  // Hard sigmoid: x/4 + 0.5 clamped to [0, 1].
  function automatic word_t hsig(word_t x);
    int v;
    v = (int'(x) >>> 2) + LSTM_ONE / 2;
    if (v < 0) v = 0;
    if (v > LSTM_ONE) v = LSTM_ONE;
    return v[LSTM_WIDTH-1:0];
  endfunction

  // Hard tanh: clamp to [-1, 1].
  function automatic word_t htanh(word_t x);
    word_t r;
    if (x > ONE_W) begin
      r = ONE_W;
    end else if (x < NEG_ONE_W) begin
      r = NEG_ONE_W;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/lstm_gate.sv
// One gate's saturated preactivation: wx*x + bx + wh*h + bh.
module lstm_gate
  import lstm_pkg::*;
(
  input  word_t wx_i,
  input  word_t wh_i,
  input  word_t bx_i,
  input  word_t bh_i,
  input  word_t x_i,
  input  word_t h_i,
  output word_t pre_o
);

  pre_t sum;

  // Accumulate in WIDTH+3 bits, then saturate back to a word.
  always_comb begin
    sum   = pre_t'(mul(wx_i, x_i)) + pre_t'(bx_i) + pre_t'(mul(wh_i, h_i)) + pre_t'(bh_i);
    pre_o = sat(wide_t'(sum));
  end

endmodule

// File: rtl/lstm_cell.sv
// Scalar LSTM cell, 5-cycle sequencer: IDLE -> PRE -> ACT -> CELL -> OUT.
// Optional macro LSTM_ROUND_EN (see lstm_pkg) selects round-half-up multiplies.
module lstm_cell
  import lstm_pkg::*;
#(
  parameter int unsigned WEIGHTS = 4,
  parameter int unsigned WIDTH   = LSTM_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [WEIGHTS*WIDTH-1:0]   weight_x,
  input  logic signed [WEIGHTS*WIDTH-1:0]   weight_h,
  input  logic signed [WEIGHTS*WIDTH-1:0]   bias_x,
  input  logic signed [WEIGHTS*WIDTH-1:0]   bias_h,
  input  logic signed [WIDTH-1:0]           C_in,
  input  logic signed [WIDTH-1:0]           h_in,
  input  logic signed [WIDTH-1:0]           x_in,
  input  logic                              x_valid,
  output logic                              x_ready,
  output logic signed [WIDTH-1:0]           C_out,
  output logic signed [WIDTH-1:0]           y_out,
  output logic                              y_valid
);

  state_e state_q, state_d;

  logic [WEIGHTS*WIDTH-1:0] wx_q, wh_q, bx_q, bh_q;
  word_t c_in_q, h_q, x_q;
  word_t pre_w [WEIGHTS];
  word_t pre_q [WEIGHTS];
  word_t act_q [WEIGHTS];
  word_t c_out_q, y_out_q, c_d, y_d;
  logic  y_valid_q;

  for (genvar k = 0; k < WEIGHTS; k++) begin : g_gate
    lstm_gate u_gate (
      .wx_i  (wx_q[k*WIDTH +: WIDTH]),
      .wh_i  (wh_q[k*WIDTH +: WIDTH]),
      .bx_i  (bx_q[k*WIDTH +: WIDTH]),
      .bh_i  (bh_q[k*WIDTH +: WIDTH]),
      .x_i   (x_q),
      .h_i   (h_q),
      .pre_o (pre_w[k])
    );
  end

  // Sequencer: one cycle per stage, leave IDLE only on a handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (x_valid) state_d = StPre;
      StPre:   state_d = StAct;
      StAct:   state_d = StCell;
      StCell:  state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Cell update and hidden output from the registered gate activations.
  always_comb begin
    c_d = sat(wide_t'(mul(act_q[GATE_F], c_in_q)) + wide_t'(mul(act_q[GATE_I], act_q[GATE_G])));
    y_d = sat(wide_t'(mul(act_q[GATE_O], htanh(c_out_q))));
  end

  // State and datapath registers; each stage writes only its own registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      wx_q      <= '0;
      wh_q      <= '0;
      bx_q      <= '0;
      bh_q      <= '0;
      c_in_q    <= '0;
      h_q       <= '0;
      x_q       <= '0;
      c_out_q   <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      for (int unsigned k = 0; k < WEIGHTS; k++) begin
        pre_q[k] <= '0;
        act_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      y_valid_q <= 1'b0;
      if (state_q == StIdle && x_valid) begin
        wx_q   <= weight_x;
        wh_q   <= weight_h;
        bx_q   <= bias_x;
        bh_q   <= bias_h;
        c_in_q <= C_in;
        h_q    <= h_in;
        x_q    <= x_in;
      end
      if (state_q == StPre) begin
        for (int unsigned k = 0; k < WEIGHTS; k++) pre_q[k] <= pre_w[k];
      end
      if (state_q == StAct) begin
        act_q[GATE_I] <= hsig(pre_q[GATE_I]);
        act_q[GATE_F] <= hsig(pre_q[GATE_F]);
        act_q[GATE_G] <= htanh(pre_q[GATE_G]);
        act_q[GATE_O] <= hsig(pre_q[GATE_O]);
      end
      if (state_q == StCell) c_out_q <= c_d;
      if (state_q == StOut) begin
        y_out_q   <= y_d;
        y_valid_q <= 1'b1;
      end
    end
  end

  assign x_ready = (state_q == StIdle);
  assign C_out   = c_out_q;
  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;

endmodule

// File: tb/tb_lstm_cell.sv
// Scoreboard bench for lstm_cell: driver pushes expected results, monitor pops on y_valid.
module tb_lstm_cell;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [63:0] weight_x, weight_h, bias_x, bias_h;
  logic signed [15:0] C_in, h_in, x_in;
  logic               x_valid;
  logic               x_ready;
  logic signed [15:0] C_out, y_out;
  logic               y_valid;

  typedef struct {
    int c;
    int y;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  lstm_cell dut (
    .clk      (clk),
    .rst      (rst),
    .weight_x (weight_x),
    .weight_h (weight_h),
    .bias_x   (bias_x),
    .bias_h   (bias_h),
    .C_in     (C_in),
    .h_in     (h_in),
    .x_in     (x_in),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .C_out    (C_out),
    .y_out    (y_out),
    .y_valid  (y_valid)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic on wide integers.
  function automatic longint m_mul(longint a, longint b);
    longint p;
    p = a * b;
`ifdef LSTM_ROUND_EN
    p = p + 2048;
`endif
    return p >>> 12;
  endfunction

  function automatic longint m_sat(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint m_hsig(longint v);
    longint r;
    r = (v >>> 2) + 2048;
    if (r < 0) r = 0;
    if (r > 4096) r = 4096;
    return r;
  endfunction

  function automatic longint m_htanh(longint v);
    if (v > 4096) return 4096;
    if (v < -4096) return -4096;
    return v;
  endfunction

  function automatic logic [63:0] pk(input int g, input int v);
    logic [63:0] r;
    r = '0;
    r[g*16 +: 16] = v[15:0];
    return r;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic scramble();
    weight_x = {$urandom(), $urandom()};
    weight_h = {$urandom(), $urandom()};
    bias_x   = {$urandom(), $urandom()};
    bias_h   = {$urandom(), $urandom()};
    C_in     = 16'($urandom());
    h_in     = 16'($urandom());
    x_in     = 16'($urandom());
  endtask

  // Present one sample, wait (bounded) for acceptance, optionally queue its expectation.
  task automatic send(input logic [63:0] wx, input logic [63:0] wh, input logic [63:0] bx,
                      input logic [63:0] bh, input int c, input int h, input int x,
                      input int ec, input int ey, input bit push);
    int n;
    weight_x = wx;
    weight_h = wh;
    bias_x   = bx;
    bias_h   = bh;
    C_in     = 16'(c);
    h_in     = 16'(h);
    x_in     = 16'(x);
    x_valid  = 1'b1;
    n = 0;
    while (!x_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!x_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: x_ready got 0, expected 1");
    end
    @(posedge clk);
    #1;
    if (push) sb.push_back('{ec, ey, cyc});
    x_valid = 1'b0;
    scramble();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: pending got %0d, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every y_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst && y_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_y_valid: got 1, expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("C_out", int'(C_out), e.c);
        check("y_out", int'(y_out), e.y);
        check("latency", cyc - e.acc, 4);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wx[4], wh[4], bx[4], bh[4], ci, hi, xi;
    longint pre[4], gi, gf, gg, go, ec, ey;
    logic [63:0] vwx, vwh, vbx, vbh;

    rst      = 1'b0;
    x_valid  = 1'b0;
    weight_x = '0;
    weight_h = '0;
    bias_x   = '0;
    bias_h   = '0;
    C_in     = '0;
    h_in     = '0;
    x_in     = '0;

    // Reset
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_C_out", int'(C_out), 0);
    check("reset_y_out", int'(y_out), 0);
    check("reset_y_valid", int'(y_valid), 0);
    check("reset_x_ready", int'(x_ready), 1);

    // Zero parameters: i=f=o=0.5, g=0
    send('0, '0, '0, '0, 4096, 123, -77, 2048, 1024, 1'b1);
    drain();

    // Forget-gate preactivation saturates
    send('0, '0, pk(1, 32767), pk(1, 32767), -8192, 500, -300, -8192, -2048, 1'b1);
    drain();

    // Candidate path
    send(pk(2, 4096), '0, '0, '0, 0, 0, 2048, 1024, 512, 1'b1);
    drain();

    // Reset during S_ACT aborts the result and clears the outputs
    send(pk(2, 4096), '0, '0, '0, 0, 0, 2048, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_C_out", int'(C_out), 0);
    check("abort_y_out", int'(y_out), 0);
    check("abort_x_ready", int'(x_ready), 1);

    // Rounding of a half-LSB candidate
`ifdef LSTM_ROUND_EN
    send(pk(2, 2048), '0, '0, '0, 0, 0, 1, 1, 1, 1'b1);
`else
    send(pk(2, 2048), '0, '0, '0, 0, 0, 1, 0, 0, 1'b1);
`endif
    drain();

    // Back-to-back with x_valid held high and inputs changing every cycle
    x_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        wx[k] = rnd(-8192, 8191);
        wh[k] = rnd(-8192, 8191);
        bx[k] = rnd(-4096, 4095);
        bh[k] = rnd(-4096, 4095);
        vwx[k*16 +: 16] = wx[k][15:0];
        vwh[k*16 +: 16] = wh[k][15:0];
        vbx[k*16 +: 16] = bx[k][15:0];
        vbh[k*16 +: 16] = bh[k][15:0];
      end
      ci = rnd(-16384, 16383);
      hi = rnd(-8192, 8191);
      xi = rnd(-8192, 8191);
      for (int k = 0; k < 4; k++) begin
        pre[k] = m_sat(m_mul(wx[k], xi) + bx[k] + m_mul(wh[k], hi) + bh[k]);
      end
      gi = m_hsig(pre[0]);
      gf = m_hsig(pre[1]);
      gg = m_htanh(pre[2]);
      go = m_hsig(pre[3]);
      ec = m_sat(m_mul(gf, ci) + m_mul(gi, gg));
      ey = m_sat(m_mul(go, m_htanh(ec)));
      weight_x = vwx;
      weight_h = vwh;
      bias_x   = vbx;
      bias_h   = vbh;
      C_in     = 16'(ci);
      h_in     = 16'(hi);
      x_in     = 16'(xi);
      check("b2b_x_ready_idle", int'(x_ready), 1);
      @(posedge clk);
      #1;
      sb.push_back('{int'(ec), int'(ey), cyc});
      for (int t = 0; t < 4; t++) begin
        scramble();
        @(negedge clk);
        check("b2b_x_ready_busy", int'(x_ready), 0);
        @(posedge clk);
        #1;
      end
    end
    x_valid = 1'b0;
    drain();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
